// File: rtl/rider_steer_if.sv
// A2D-side bundle for the rider steering controller: load-cell/battery readings
// in one direction, the conversion request strobe in the other.
interface rider_steer_if;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] batt;
  logic        nxt;

  modport master (output lft_ld, output rght_ld, output batt, input nxt);
  modport slave  (input lft_ld, input rght_ld, input batt, output nxt);
endinterface

// File: rtl/rider_steer_ctrl.sv
// Rider presence / balance qualifier, A2D conversion strobe and low-battery flag.
// Define RIDER_STEER_FAST_SIM_EN to shorten the steer-enable settle time to 2^15 clocks.
module rider_steer_ctrl #(
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] WT_HYSTERESIS = 12'h040,
  parameter logic [11:0] BATT_THRES    = 12'h800,
  parameter logic [15:0] NXT_PERIOD    = 16'd4096
) (
  input  logic           clk,
  input  logic           rst,
  rider_steer_if.slave   a2d,
  output logic           en_steer,
  output logic           rider_off,
  output logic           batt_low
);

  typedef enum logic [1:0] {IDLE, WAIT, STEER_EN} state_t;

  localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYSTERESIS};
  localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

  function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  state_t      state;
  logic [25:0] tmr;
  logic [15:0] nxt_cnt;
  logic [12:0] sum;
  logic [11:0] diff;
  logic        sum_gt_min;
  logic        sum_lt_min;
  logic        diff_gt_1_4;
  logic        diff_gt_15_16;
  logic        tmr_full;

  assign sum           = {1'b0, a2d.lft_ld} + {1'b0, a2d.rght_ld};
  assign diff          = abs_diff(a2d.lft_ld, a2d.rght_ld);
  assign sum_gt_min    = sum > SUM_HI;
  assign sum_lt_min    = sum < SUM_LO;
  assign diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
  assign diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));

`ifdef RIDER_STEER_FAST_SIM_EN
  assign tmr_full = &tmr[14:0];
`else
  assign tmr_full = &tmr;
`endif

  // Outputs are registered with the state so they always equal the decode of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      tmr       <= '0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (sum_gt_min) begin
            state     <= WAIT;
            tmr       <= '0;
            rider_off <= 1'b0;
          end
        end
        WAIT: begin
          if (sum_lt_min) begin
            state     <= IDLE;
            rider_off <= 1'b1;
          end else if (diff_gt_1_4) begin
            tmr <= '0;
          end else if (tmr_full) begin
            state    <= STEER_EN;
            en_steer <= 1'b1;
          end else begin
            tmr <= tmr + 26'd1;
          end
        end
        STEER_EN: begin
          if (sum_lt_min) begin
            state     <= IDLE;
            en_steer  <= 1'b0;
            rider_off <= 1'b1;
          end else if (diff_gt_15_16) begin
            state    <= WAIT;
            tmr      <= '0;
            en_steer <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          en_steer  <= 1'b0;
          rider_off <= 1'b1;
        end
      endcase
    end
  end

  // nxt is registered off the terminal count, so the first pulse lands a full period after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_cnt  <= '0;
      a2d.nxt  <= 1'b0;
      batt_low <= 1'b0;
    end else begin
      a2d.nxt <= (nxt_cnt == NXT_PERIOD - 16'd1);
      if (nxt_cnt == NXT_PERIOD - 16'd1) nxt_cnt <= '0;
      else                               nxt_cnt <= nxt_cnt + 16'd1;
      if (a2d.nxt) batt_low <= (a2d.batt < BATT_THRES);
    end
  end

endmodule
